// File: rtl/fetch_sequencer.sv
// picoMIPS program counter and fetch phase controller (IDLE/RUN/WAIT/HALT).
// Optional single-entry call/return link register: FETCH_SEQUENCER_LINK_REG_EN.
module fetch_sequencer #(
  parameter int P_SIZE = 5,
  parameter logic [P_SIZE-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startIn,
  input  logic              stallIn,
  input  logic              branchIn,
  input  logic              branchRelIn,
  input  logic [P_SIZE-1:0] branchTargetIn,
  input  logic              waitIn,
  input  logic              readyIn,
  input  logic              haltIn,
`ifdef FETCH_SEQUENCER_LINK_REG_EN
  input  logic              callIn,
  input  logic              retIn,
`endif
  output logic [P_SIZE-1:0] addressOut,
  output logic              runningOut,
  output logic              waitingOut,
  output logic              haltedOut,
  output logic              ackOut
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT,
    HALT
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [P_SIZE-1:0] pc;
  logic [P_SIZE-1:0] pc_n;
  logic [P_SIZE-1:0] pc_inc;
  logic [P_SIZE-1:0] pc_rel;
  logic              armed;
  logic              armed_n;
  logic              ack_n;

`ifdef FETCH_SEQUENCER_LINK_REG_EN
  logic [P_SIZE-1:0] link;
  logic [P_SIZE-1:0] link_n;
`endif

  // Same-width add wraps modulo 2^P_SIZE for both increment and offset.
  assign pc_inc = pc + P_SIZE'(1);
  assign pc_rel = pc + branchTargetIn;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    armed_n = armed;
    ack_n   = 1'b0;
`ifdef FETCH_SEQUENCER_LINK_REG_EN
    link_n  = link;
`endif
    case (state)
      IDLE: begin
        if (startIn) state_n = RUN;
      end
      RUN: begin
        if (stallIn) begin
          state_n = RUN;
        end else if (haltIn) begin
          state_n = HALT;
        end else if (waitIn) begin
          state_n = WAIT;
          armed_n = 1'b0;
`ifdef FETCH_SEQUENCER_LINK_REG_EN
        end else if (callIn) begin
          link_n  = pc_inc;
          pc_n    = branchTargetIn;
        end else if (retIn) begin
          pc_n    = link;
`endif
        end else if (branchIn && branchRelIn) begin
          pc_n    = pc_rel;
        end else if (branchIn) begin
          pc_n    = branchTargetIn;
        end else begin
          pc_n    = pc_inc;
        end
      end
      WAIT: begin
        // A level already high on entry must drop before it can fire.
        if (!armed) begin
          if (!readyIn) armed_n = 1'b1;
        end else if (readyIn) begin
          armed_n = 1'b0;
          pc_n    = pc_inc;
          state_n = RUN;
          ack_n   = 1'b1;
        end
      end
      HALT: begin
        state_n = HALT;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= START_ADDR;
      armed      <= 1'b0;
      ackOut     <= 1'b0;
      runningOut <= 1'b0;
      waitingOut <= 1'b0;
      haltedOut  <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      armed      <= armed_n;
      ackOut     <= ack_n;
      runningOut <= (state_n == RUN);
      waitingOut <= (state_n == WAIT);
      haltedOut  <= (state_n == HALT);
    end
  end

`ifdef FETCH_SEQUENCER_LINK_REG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) link <= '0;
    else       link <= link_n;
  end
`endif

  assign addressOut = pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized bench for fetch_sequencer.
// Checks every cycle against a phase/PC model of the sequencer rules.
module tb_fetch_sequencer;

  localparam int P = 5;
  localparam int DEPTH = 1 << P;

  logic         clk = 1'b0;
  logic         reset;
  logic         startIn;
  logic         stallIn;
  logic         branchIn;
  logic         branchRelIn;
  logic [P-1:0] branchTargetIn;
  logic         waitIn;
  logic         readyIn;
  logic         haltIn;
  logic         callIn;
  logic         retIn;
  logic [P-1:0] addressOut;
  logic         runningOut;
  logic         waitingOut;
  logic         haltedOut;
  logic         ackOut;

  int checks = 0;
  int failures = 0;

  // model: phase 0 idle, 1 run, 2 wait, 3 halt
  int m_phase;
  int m_pc;
  int m_link;
  bit m_seen_low;
  bit m_ack;
  bit link_en;

  fetch_sequencer #(.P_SIZE(P), .START_ADDR('0)) dut (
    .clk(clk),
    .reset(reset),
    .startIn(startIn),
    .stallIn(stallIn),
    .branchIn(branchIn),
    .branchRelIn(branchRelIn),
    .branchTargetIn(branchTargetIn),
    .waitIn(waitIn),
    .readyIn(readyIn),
    .haltIn(haltIn),
`ifdef FETCH_SEQUENCER_LINK_REG_EN
    .callIn(callIn),
    .retIn(retIn),
`endif
    .addressOut(addressOut),
    .runningOut(runningOut),
    .waitingOut(waitingOut),
    .haltedOut(haltedOut),
    .ackOut(ackOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pc"}, 32'(addressOut), 32'(m_pc));
    chk({tag, ".run"}, 32'(runningOut), 32'(m_phase == 1));
    chk({tag, ".wait"}, 32'(waitingOut), 32'(m_phase == 2));
    chk({tag, ".halt"}, 32'(haltedOut), 32'(m_phase == 3));
    chk({tag, ".ack"}, 32'(ackOut), 32'(m_ack));
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pc = 0;
    m_link = 0;
    m_seen_low = 0;
    m_ack = 0;
  endtask

  task automatic model_edge();
    int off;
    m_ack = 0;
    if (m_phase == 0) begin
      if (startIn) m_phase = 1;
    end else if (m_phase == 1) begin
      off = (branchTargetIn >= DEPTH / 2) ? int'(branchTargetIn) - DEPTH
                                          : int'(branchTargetIn);
      if (stallIn) begin
      end else if (haltIn) m_phase = 3;
      else if (waitIn) begin
        m_phase = 2;
        m_seen_low = 0;
      end else if (link_en && callIn) begin
        m_link = (m_pc + 1) % DEPTH;
        m_pc = int'(branchTargetIn);
      end else if (link_en && retIn) m_pc = m_link;
      else if (branchIn && branchRelIn) m_pc = (m_pc + off + DEPTH) % DEPTH;
      else if (branchIn) m_pc = int'(branchTargetIn);
      else m_pc = (m_pc + 1) % DEPTH;
    end else if (m_phase == 2) begin
      if (!readyIn) m_seen_low = 1;
      else if (m_seen_low) begin
        m_pc = (m_pc + 1) % DEPTH;
        m_phase = 1;
        m_ack = 1;
      end
    end
  endtask

  task automatic quiet();
    startIn = 0; stallIn = 0; branchIn = 0; branchRelIn = 0;
    branchTargetIn = '0; waitIn = 0; readyIn = 0; haltIn = 0;
    callIn = 0; retIn = 0;
  endtask

  // inputs are set just after an edge; model and DUT both sample next edge
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  task automatic jump(input int t);
    quiet();
    branchIn = 1;
    branchTargetIn = P'(t);
    step("jump");
    quiet();
  endtask

  task automatic reset_pulse(input string tag);
    reset = 1;
    #2;
    model_reset();
    chk_model(tag);
    reset = 0;
  endtask

  initial begin
    link_en = 0;
`ifdef FETCH_SEQUENCER_LINK_REG_EN
    link_en = 1;
`endif
    quiet();
    reset = 1;
    model_reset();
    #3;
    chk_model("reset");
    @(posedge clk);
    #1;
    reset = 0;
    chk_model("reset_held");

    step("idle_hold");
    chk("idle_pc", 32'(addressOut), 0);

    startIn = 1;
    step("start");
    chk("start_pc", 32'(addressOut), 0);
    startIn = 0;
    for (int i = 1; i <= 3; i++) begin
      step("run_seq");
      chk("run_seq_pc", 32'(addressOut), 32'(i));
    end

    jump(30);
    chk("at30", 32'(addressOut), 30);
    step("wrap31");
    chk("wrap31_pc", 32'(addressOut), 31);
    step("wrap0");
    chk("wrap0_pc", 32'(addressOut), 0);
    jump(7);
    chk("abs7", 32'(addressOut), 7);

    jump(2);
    branchIn = 1; branchRelIn = 1; branchTargetIn = 5'b11101;
    step("rel_neg3");
    chk("rel_pc", 32'(addressOut), 31);
    jump(4);
    stallIn = 1;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall_pc", 32'(addressOut), 4);
    end
    quiet();

    jump(9);
    waitIn = 1; readyIn = 1;
    step("wait_enter");
    waitIn = 0;
    chk("wait_pc", 32'(addressOut), 9);
    for (int i = 0; i < 3; i++) begin
      branchIn = 1; haltIn = 1; stallIn = 1;
      step("wait_held_high");
      chk("wait_hold_pc", 32'(addressOut), 9);
    end
    quiet();
    step("wait_arm");
    readyIn = 1;
    step("wait_fire");
    chk("fire_pc", 32'(addressOut), 10);
    chk("fire_ack", 32'(ackOut), 1);
    step("after_fire");
    chk("ack_pulse", 32'(ackOut), 0);
    readyIn = 0;

    jump(12);
    haltIn = 1; branchIn = 1; branchTargetIn = 5'd3;
    step("halt_enter");
    for (int i = 0; i < 20; i++) begin
      startIn = 1'($urandom); branchIn = 1'($urandom);
      waitIn = 1'($urandom); readyIn = 1'($urandom);
      branchTargetIn = P'($urandom);
      step("halt_hold");
      chk("halt_pc", 32'(addressOut), 12);
    end
    quiet();
    reset_pulse("async_reset");
    chk("async_pc", 32'(addressOut), 0);

    if (link_en) begin
      startIn = 1;
      step("l_start");
      jump(5);
      callIn = 1; branchTargetIn = 5'd20;
      step("call");
      chk("call_pc", 32'(addressOut), 20);
      quiet();
      step("l_21");
      step("l_22");
      retIn = 1;
      step("ret");
      chk("ret_pc", 32'(addressOut), 6);
      quiet();
    end

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        quiet();
        reset_pulse("rnd_reset");
      end
      startIn = ($urandom_range(0, 99) < 30);
      stallIn = ($urandom_range(0, 99) < 15);
      haltIn = ($urandom_range(0, 99) < 2);
      waitIn = ($urandom_range(0, 99) < 12);
      branchIn = ($urandom_range(0, 99) < 25);
      branchRelIn = 1'($urandom);
      branchTargetIn = P'($urandom);
      readyIn = ($urandom_range(0, 99) < 40);
      callIn = ($urandom_range(0, 99) < 10);
      retIn = ($urandom_range(0, 99) < 10);
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
